// File: rtl/host_message_handler_pkg.sv
// Shared constants, state encoding and helpers for the host message handler.
// Message byte values are part of the host protocol and must match the host software.
package host_message_handler_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  // Result message: iteration count, cycle count high byte, cycle count low byte.
  localparam int unsigned TX_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HEADER,
    RX_MEAS,
    START,
    DECODE,
    TX
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/host_message_handler.sv
// Host-side protocol engine: receives a syndrome frame, kicks the decoder core,
// then returns iteration count and decode cycle count as a 3-byte message.
module host_message_handler
  import host_message_handler_pkg::*;
#(
  parameter int GRID_WIDTH_X = 4,
  parameter int GRID_WIDTH_Z = 1,
  parameter int GRID_WIDTH_U = 3,
  localparam int BYTES_PER_ROUND      = (GRID_WIDTH_X * GRID_WIDTH_Z + 7) / 8,
  localparam int ALIGNED_PU_PER_ROUND = 8 * BYTES_PER_ROUND
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [7:0]                                   input_data,
  input  logic                                         input_valid,
  output logic                                         input_ready,
  output logic [7:0]                                   output_data,
  output logic                                         output_valid,
  input  logic                                         output_ready,
  output logic [ALIGNED_PU_PER_ROUND*GRID_WIDTH_U-1:0] measurements,
  output logic                                         start_decoding,
  input  logic                                         result_valid,
  input  logic [7:0]                                   iteration_count,
  output logic                                         protocol_error
);

  localparam int unsigned TOTAL_BYTES = BYTES_PER_ROUND * GRID_WIDTH_U;
  localparam int unsigned CNT_W       = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(TOTAL_BYTES - 1);
  localparam logic [1:0]       LAST_TX   = 2'(TX_BYTES - 1);
  localparam int unsigned MEAS_W = ALIGNED_PU_PER_ROUND * GRID_WIDTH_U;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  byte_cnt;
  logic [15:0]       cycle_cnt;
  logic [7:0]        iter_q;
  logic [1:0]        tx_idx;
  logic [MEAS_W-1:0] meas_q;
  logic              fire_in;

  assign measurements = meas_q;
  assign fire_in      = input_valid & input_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt  <= '0;
      cycle_cnt <= '0;
      iter_q    <= '0;
      tx_idx    <= '0;
      meas_q    <= '0;
    end else begin
      case (state)
        WAIT_HEADER: begin
          if (fire_in && input_data == MEASUREMENT_DATA_HEADER) begin
            meas_q   <= '0;
            byte_cnt <= '0;
          end
        end
        RX_MEAS: begin
          if (fire_in) begin
            for (int unsigned i = 0; i < TOTAL_BYTES; i++) begin
              if (byte_cnt == CNT_W'(i)) begin
                meas_q[8*i +: 8] <= input_data;
              end
            end
            // Counter parks on the last byte; the header clears it for the next frame.
            if (byte_cnt != LAST_BYTE) begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        START: begin
          cycle_cnt <= '0;
          tx_idx    <= '0;
        end
        DECODE: begin
          // The completion cycle itself is included in the reported total.
          cycle_cnt <= sat_inc16(cycle_cnt);
          if (result_valid) begin
            iter_q <= iteration_count;
          end
        end
        TX: begin
          if (output_ready) begin
            tx_idx <= tx_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next     = state;
    input_ready    = 1'b0;
    output_valid   = 1'b0;
    output_data    = '0;
    start_decoding = 1'b0;
    protocol_error = 1'b0;
    case (state)
      IDLE: begin
        input_ready = 1'b1;
        if (input_valid) begin
          if (input_data == START_DECODING_MSG) begin
            state_next = WAIT_HEADER;
          end else begin
            protocol_error = 1'b1;
          end
        end
      end
      WAIT_HEADER: begin
        input_ready = 1'b1;
        if (input_valid) begin
          if (input_data == MEASUREMENT_DATA_HEADER) begin
            state_next = RX_MEAS;
          end else if (input_data != START_DECODING_MSG) begin
            protocol_error = 1'b1;
          end
        end
      end
      RX_MEAS: begin
        input_ready = 1'b1;
        if (input_valid && byte_cnt == LAST_BYTE) begin
          state_next = START;
        end
      end
      START: begin
        start_decoding = 1'b1;
        state_next     = DECODE;
      end
      DECODE: begin
        if (result_valid) begin
          state_next = TX;
        end
      end
      TX: begin
        output_valid = 1'b1;
        case (tx_idx)
          2'd0:    output_data = iter_q;
          2'd1:    output_data = cycle_cnt[15:8];
          default: output_data = cycle_cnt[7:0];
        endcase
        if (output_ready && tx_idx == LAST_TX) begin
          state_next = WAIT_HEADER;
        end
      end
      default: state_next = IDLE;
    endcase
    // Handshake outputs are forced quiet for the whole reset window, not just after the first edge.
    if (reset) begin
      input_ready    = 1'b0;
      output_valid   = 1'b0;
      output_data    = '0;
      start_decoding = 1'b0;
      protocol_error = 1'b0;
    end
  end

endmodule

// File: tb/tb_host_message_handler.sv
// Self-checking bench for host_message_handler: directed frame table, randomized
// frames against a byte-level reference model, and reset/abort sequences.
module tb_host_message_handler;
  import host_message_handler_pkg::*;

  localparam int GX = 4;
  localparam int GZ = 1;
  localparam int GU = 3;
  localparam logic [7:0] SMSG = 8'h01;
  localparam logic [7:0] HDR  = 8'h02;

  logic        clk;
  logic        reset;
  logic [7:0]  input_data;
  logic        input_valid;
  logic        input_ready;
  logic [7:0]  output_data;
  logic        output_valid;
  logic        output_ready;
  logic [23:0] measurements;
  logic        start_decoding;
  logic        result_valid;
  logic [7:0]  iteration_count;
  logic        protocol_error;

  host_message_handler #(
    .GRID_WIDTH_X(GX),
    .GRID_WIDTH_Z(GZ),
    .GRID_WIDTH_U(GU)
  ) dut (
    .clk(clk),
    .reset(reset),
    .input_data(input_data),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .output_data(output_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .measurements(measurements),
    .start_decoding(start_decoding),
    .result_valid(result_valid),
    .iteration_count(iteration_count),
    .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          npre;
    logic [7:0]  pre [4];
    logic [7:0]  b [3];
    int          delay;
    logic [7:0]  it;
    int          bp;
    logic [23:0] exp_meas;
    logic [7:0]  exp_out [3];
    int          exp_perr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Passive monitors sample handshakes at the edge where they take effect.
  int         cyc = 0;
  logic [7:0] rx_q [$];
  int         rx_cyc [$];
  int         start_cnt = 0;
  int         perr_cnt = 0;
  int         ready_in_tx = 0;
  int         hold_viol = 0;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (output_valid && output_ready) begin
        rx_q.push_back(output_data);
        rx_cyc.push_back(cyc);
      end
      if (start_decoding) start_cnt <= start_cnt + 1;
      if (protocol_error) perr_cnt <= perr_cnt + 1;
      if (output_valid && input_ready) ready_in_tx <= ready_in_tx + 1;
      if (hold_pending && (!output_valid || output_data !== hold_data)) hold_viol <= hold_viol + 1;
      hold_pending <= output_valid && !output_ready;
      hold_data    <= output_data;
    end else begin
      hold_pending <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    input_data  = d;
    input_valid = 1'b1;
    while (!input_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!input_ready) timeout("send_byte");
    @(negedge clk);
    input_valid = 1'b0;
    input_data  = '0;
  endtask

  task automatic run_decode(input int delay, input logic [7:0] it, input string tag,
                            input logic [23:0] exp_meas);
    int n = 0;
    while (!start_decoding && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!start_decoding) timeout({tag, "_start"});
    chk({tag, "_meas"}, measurements, exp_meas);
    repeat (delay) @(negedge clk);
    result_valid    = 1'b1;
    iteration_count = it;
    @(negedge clk);
    result_valid    = 1'b0;
    iteration_count = 8'($urandom);
    chk({tag, "_meas_hold"}, measurements, exp_meas);
  endtask

  task automatic drain(input int bp, input string tag, input logic [7:0] exp_out [3]);
    int n = 0;
    while (!output_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!output_valid) timeout({tag, "_tx"});
    if (bp == 0) begin
      output_ready = 1'b1;
      n = 0;
      while (rx_q.size() < 3 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end else begin
      for (int b = 0; b < 3; b++) begin
        output_ready = 1'b0;
        repeat (bp) @(negedge clk);
        output_ready = 1'b1;
        @(negedge clk);
      end
    end
    output_ready = 1'b0;
    chk({tag, "_nbytes"}, rx_q.size(), 3);
    chk({tag, "_valid_drop"}, {output_valid, input_ready}, 2'b01);
    for (int b = 0; b < 3; b++) begin
      if (rx_q.size() > 0) chk($sformatf("%s_byte%0d", tag, b), rx_q.pop_front(), exp_out[b]);
    end
  endtask

  task automatic frame(input vec_t v, input string tag);
    int p0 = perr_cnt;
    int s0 = start_cnt;
    rx_q.delete();
    rx_cyc.delete();
    for (int p = 0; p < v.npre; p++) send_byte(v.pre[p]);
    send_byte(HDR);
    // A stray completion while receiving must be ignored.
    result_valid    = 1'b1;
    iteration_count = 8'hEE;
    send_byte(v.b[0]);
    send_byte(v.b[1]);
    result_valid    = 1'b0;
    send_byte(v.b[2]);
    run_decode(v.delay, v.it, tag, v.exp_meas);
    drain(v.bp, tag, v.exp_out);
    if (v.bp == 0 && rx_cyc.size() == 3) chk({tag, "_nobubble"}, rx_cyc[2] - rx_cyc[0], 2);
    chk({tag, "_perr"}, perr_cnt - p0, v.exp_perr);
    chk({tag, "_starts"}, start_cnt - s0, 1);
  endtask

  function automatic vec_t model(input int npre, input logic [7:0] pre [4], input logic [7:0] b [3],
                                 input int delay, input logic [7:0] it, input int bp);
    vec_t v;
    v.npre     = npre;
    v.pre      = pre;
    v.b        = b;
    v.delay    = delay;
    v.it       = it;
    v.bp       = bp;
    v.exp_perr = 0;
    for (int p = 0; p < npre; p++) if (pre[p] != SMSG) v.exp_perr++;
    v.exp_meas = '0;
    for (int i = 0; i < 3; i++) v.exp_meas = v.exp_meas | (24'(b[i]) << (8 * i));
    v.exp_out[0] = it;
    v.exp_out[1] = 8'((delay > 65535 ? 65535 : delay) / 256);
    v.exp_out[2] = 8'((delay > 65535 ? 65535 : delay) % 256);
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    vec_t v;
    logic [7:0] pre [4];
    logic [7:0] b [3];
    int s0;

    tbl[0] = '{3, '{8'hFF, 8'h01, 8'h01, 8'h00}, '{8'h05, 8'h00, 8'h0A}, 7, 8'h03, 0,
               24'h0A0005, '{8'h03, 8'h00, 8'h07}, 1};
    tbl[1] = '{0, '{8'h00, 8'h00, 8'h00, 8'h00}, '{8'h05, 8'h00, 8'h0A}, 7, 8'h03, 5,
               24'h0A0005, '{8'h03, 8'h00, 8'h07}, 0};
    tbl[2] = '{0, '{8'h00, 8'h00, 8'h00, 8'h00}, '{8'hFF, 8'h80, 8'h01}, 1, 8'hFF, 0,
               24'h0180FF, '{8'hFF, 8'h00, 8'h01}, 0};
    tbl[3] = '{2, '{8'h01, 8'h3C, 8'h00, 8'h00}, '{8'h12, 8'h34, 8'h56}, 300, 8'h00, 1,
               24'h563412, '{8'h00, 8'h01, 8'h2C}, 1};

    reset = 1'b1;
    input_data = '0;
    input_valid = 1'b0;
    output_ready = 1'b0;
    result_valid = 1'b0;
    iteration_count = '0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {input_ready, output_valid, output_data, start_decoding,
                            protocol_error, measurements}, '0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", input_ready, 1'b1);

    for (int t = 0; t < 4; t++) frame(tbl[t], $sformatf("tbl%0d", t));

    for (int r = 0; r < 16; r++) begin
      int npre = $urandom_range(0, 2);
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 1) == 1) pre[p] = SMSG;
        else begin
          pre[p] = 8'($urandom);
          while (pre[p] == SMSG || pre[p] == HDR) pre[p] = 8'($urandom);
        end
      end
      for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
      v = model(npre, pre, b, $urandom_range(1, 40), 8'($urandom), $urandom_range(0, 3));
      frame(v, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of a frame: nothing may leak out, then a fresh frame works.
    s0 = start_cnt;
    send_byte(HDR);
    send_byte(8'h77);
    reset = 1'b1;
    input_valid = 1'b1;
    input_data = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("midrx_reset_outputs", {input_ready, output_valid, output_data, start_decoding,
                                  protocol_error, measurements}, '0);
    end
    reset = 1'b0;
    input_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrx_no_start", start_cnt - s0, 0);
    pre = '{8'h01, 8'h00, 8'h00, 8'h00};
    b = '{8'hAA, 8'hBB, 8'hCC};
    frame(model(1, pre, b, 2, 8'h09, 0), "post_reset");

    // Reset while a result byte is pending: the message is dropped.
    send_byte(HDR);
    for (int i = 0; i < 3; i++) send_byte(8'(i + 1));
    run_decode(3, 8'h44, "abort", 24'h030201);
    chk("abort_tx_valid", output_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    output_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_tx", {output_valid, input_ready}, 2'b01);
    end
    output_ready = 1'b0;

    chk("hold_stable", hold_viol, 0);
    chk("no_input_during_tx", ready_in_tx, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_message_handler.md
HOST_MESSAGE_HANDLER -- requirements
Module: host_message_handler

Interface
REQ-001 SHALL have parameter GRID_WIDTH_X, default 4, meaning X width of the per-round measurement grid.
REQ-002 SHALL have parameter GRID_WIDTH_Z, default 1, meaning Z width of the per-round measurement grid.
REQ-003 SHALL have parameter GRID_WIDTH_U, default 3, meaning number of measurement rounds.
REQ-004 SHALL derive BYTES_PER_ROUND = ceil(GRID_WIDTH_X*GRID_WIDTH_Z/8) and ALIGNED_PU_PER_ROUND = 8*BYTES_PER_ROUND.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports input_data, input, 8 bits; input_valid, input, 1 bit; input_ready, output, 1 bit: the host-to-decoder byte stream.
REQ-008 SHALL have ports output_data, output, 8 bits; output_valid, output, 1 bit; output_ready, input, 1 bit: the decoder-to-host byte stream.
REQ-009 SHALL have port measurements, output, ALIGNED_PU_PER_ROUND*GRID_WIDTH_U bits: the assembled syndrome image.
REQ-010 SHALL have port start_decoding, output, 1 bit: a one-cycle pulse telling the decoder core to begin.
REQ-011 SHALL have ports result_valid, input, 1 bit, and iteration_count, input, 8 bits: core completion and iteration count.
REQ-012 SHALL have port protocol_error, output, 1 bit: a one-cycle pulse when an unexpected byte is discarded.

Function
REQ-013 SHALL transfer a byte on either stream only in a cycle where valid and ready are both high.
REQ-014 SHALL implement states IDLE, WAIT_HEADER, RX_MEAS, START, DECODE and TX.
REQ-015 SHALL drive input_ready=1 in IDLE, WAIT_HEADER and RX_MEAS, and input_ready=0 in all other states.
REQ-016 In IDLE, SHALL move to WAIT_HEADER on START_DECODING_MSG and otherwise discard the byte and pulse protocol_error.
REQ-017 In WAIT_HEADER, SHALL clear measurements to 0, zero the byte counter and move to RX_MEAS on MEASUREMENT_DATA_HEADER.
REQ-018 In WAIT_HEADER, SHALL discard START_DECODING_MSG silently and discard any other byte with a protocol_error pulse.
REQ-019 In RX_MEAS, SHALL write accepted byte n to measurements[8n+7:8n], with n counting from 0.
REQ-020 SHALL move from RX_MEAS to START after byte BYTES_PER_ROUND*GRID_WIDTH_U-1; the byte counter SHALL NOT wrap or overrun.
REQ-021 START SHALL last exactly one cycle with start_decoding=1, clear the 16-bit cycle counter and go to DECODE.
REQ-022 In DECODE, SHALL increment the cycle counter every cycle, saturating at 16'hFFFF.
REQ-023 SHALL capture iteration_count and the final cycle count and go to TX when result_valid is sampled in DECODE; that cycle counts toward the cycle total.
REQ-024 SHALL ignore result_valid outside DECODE.
REQ-025 In TX, SHALL send three bytes in order: iteration_count, cycle_count[15:8], cycle_count[7:0].
REQ-026 SHALL hold output_valid and output_data stable until the byte is accepted, with no bubble between bytes while output_ready stays high.
REQ-027 After the third byte is accepted, SHALL drop output_valid in the next cycle and return to WAIT_HEADER.
REQ-028 SHALL keep the measurements output stable from START until the next MEASUREMENT_DATA_HEADER.

Reset
REQ-029 While reset=1, SHALL enter IDLE, zero all counters and measurements, and drive input_ready=0, output_valid=0, output_data=0, start_decoding=0 and protocol_error=0.
REQ-030 On reset asserted in any state, SHALL abort the state's activity, discard partial frames and in-progress TX bytes, and not emit start_decoding.

Structure
REQ-031 SHALL take START_DECODING_MSG, MEASUREMENT_DATA_HEADER and the state enum from the shared parameters package.
REQ-032 SHALL be one module with no sub-modules; the stream FIFOs stay outside this block.

Verification
REQ-033 Reset check: with defaults (3 measurement bytes), hold reset 3 cycles mid-RX_MEAS -> all outputs 0, then a fresh frame decodes normally.
REQ-034 Full frame: send START_DECODING_MSG, MEASUREMENT_DATA_HEADER, 8'h05, 8'h00, 8'h0A -> measurements=24'h0A0005, one start_decoding pulse.
REQ-035 Result return: assert result_valid on the 7th DECODE cycle with iteration_count=8'h03 -> output bytes 8'h03, 8'h00, 8'h07.
REQ-036 Backpressure: hold output_ready=0 for 5 cycles per byte -> bytes unchanged and in order, and no input accepted during TX.
REQ-037 Protocol errors: send 8'hFF in IDLE, then START_DECODING_MSG twice before the header -> exactly one protocol_error pulse, and the frame is still accepted.
REQ-038 Back-to-back frames: send a second header immediately after TX completes -> second decode completes without re-sending START_DECODING_MSG.
